// File: rtl/vlx_wb_writer.sv
// vlx_wb_writer: byte sink and Wishbone write scheduler for the VLC bit packer.
// Packer bytes are packed big-endian into 32-bit words. Completed words go
// into a small FIFO, and each entry is written to memory as one Wishbone
// master write. A small register port sets the write pointer, requests a
// flush of the final partial word, and reports status.
// Optional feature: define VLX_WB_BYTE_CNT_EN to add a 32-bit accepted-byte
// counter that is readable at register address 2.
module vlx_wb_writer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        byte_req_i,
    input  logic [7:0]  byte_dat_i,
    output logic        byte_ack_o,
    input  logic        cfg_we_i,
    input  logic [1:0]  cfg_addr_i,
    input  logic [31:0] cfg_dat_i,
    output logic [31:0] cfg_dat_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_BUS} bus_state_t;

    bus_state_t  state;
    logic [31:0] wr_ptr;
    logic [1:0]  lane;
    logic [31:0] word_buf;      // filled lanes hold bytes, unfilled lanes stay 0
    logic        err;
    logic        flush_pending;

    logic [31:0] fifo_dat [FIFO_DEPTH];
    logic [29:0] fifo_adr [FIFO_DEPTH];
    logic [3:0]  fifo_sel [FIFO_DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;

    logic        fifo_full, capture, flush_go, ptr_wr, cfg_flush, err_clr;
    logic        push, pop;
    logic [31:0] push_dat;
    logic [3:0]  push_sel;

    // Capture, flush and push decisions, all taken from pre-edge state
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        push_sel  = 4'b0000;
        fifo_full = (count == (AW+1)'(FIFO_DEPTH));
        capture   = byte_req_i && !byte_ack_o && !flush_pending &&
                    ((lane != 2'd3) || !fifo_full);
        flush_go  = flush_pending && !fifo_full;
        ptr_wr    = cfg_we_i && (cfg_addr_i == 2'd0);
        cfg_flush = cfg_we_i && (cfg_addr_i == 2'd1) && cfg_dat_i[0];
        err_clr   = cfg_we_i && (cfg_addr_i == 2'd1) && cfg_dat_i[1];
        // A pointer write discards the word under assembly, so it also cancels that push
        push      = !ptr_wr && ((capture && (lane == 2'd3)) ||
                                (flush_go && (lane != 2'd0)));
        pop       = (state == ST_BUS) && (wb_ack_i || wb_err_i);
        push_dat  = capture ? {word_buf[31:8], byte_dat_i} : word_buf;
        if (capture) begin
            push_sel = 4'b1111;
        end else begin
            case (lane)
                2'd1:    push_sel = 4'b1000;
                2'd2:    push_sel = 4'b1100;
                2'd3:    push_sel = 4'b1110;
                default: push_sel = 4'b0000;
            endcase
        end
    end

    // Byte assembly, write pointer, flush request and sticky error
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst_i) begin
            byte_ack_o    <= 1'b0;
            wr_ptr        <= 32'd0;
            lane          <= 2'd0;
            word_buf      <= 32'd0;
            flush_pending <= 1'b0;
            err           <= 1'b0;
        end else begin
            byte_ack_o <= capture;
            if (ptr_wr) begin
                wr_ptr   <= {cfg_dat_i[31:2], 2'b00};
                lane     <= 2'd0;
                word_buf <= 32'd0;
            end else if (push) begin
                wr_ptr   <= wr_ptr + 32'd4;
                lane     <= 2'd0;
                word_buf <= 32'd0;
            end else if (capture) begin
                lane <= lane + 2'd1;
                case (lane)
                    2'd0:    word_buf[31:24] <= byte_dat_i;
                    2'd1:    word_buf[23:16] <= byte_dat_i;
                    2'd2:    word_buf[15:8]  <= byte_dat_i;
                    default: ;
                endcase
            end
            if (cfg_flush)
                flush_pending <= 1'b1;
            else if (flush_go)
                flush_pending <= 1'b0;
            if (pop && wb_err_i)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk_i) begin
        // NOTE: storage has no reset; occupancy alone says which entries are valid.
        if (push) begin
            fifo_dat[tail] <= push_dat;
            fifo_adr[tail] <= wr_ptr[31:2];
            fifo_sel[tail] <= push_sel;
        end
    end

    // Bus FSM: one single write per FIFO entry, with an idle cycle between writes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= 32'd0;
            wb_dat_o <= 32'd0;
            wb_sel_o <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        state    <= ST_BUS;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= 1'b1;
                        wb_adr_o <= {fifo_adr[head], 2'b00};
                        wb_dat_o <= fifo_dat[head];
                        wb_sel_o <= fifo_sel[head];
                    end
                end
                default: begin
                    if (wb_ack_i || wb_err_i) begin
                        state    <= ST_IDLE;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_adr_o <= 32'd0;
                        wb_dat_o <= 32'd0;
                        wb_sel_o <= 4'd0;
                    end
                end
            endcase
        end
    end

    assign busy_o = (count != '0) || wb_cyc_o || flush_pending;

`ifdef VLX_WB_BYTE_CNT_EN
    logic [31:0] byte_cnt;

    // Accepted-byte counter, cleared by a pointer write and wrapping at 2^32
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            byte_cnt <= 32'd0;
        else if (ptr_wr)
            byte_cnt <= 32'd0;
        else if (capture)
            byte_cnt <= byte_cnt + 32'd1;
    end
`else
    logic [31:0] byte_cnt;
    assign byte_cnt = 32'd0;
`endif

    // Register read mux
    always_comb begin
        cfg_dat_o = 32'd0;
        case (cfg_addr_i)
            2'd0:    cfg_dat_o = wr_ptr;
            2'd1:    cfg_dat_o = {27'd0, flush_pending, lane, err, busy_o};
            2'd2:    cfg_dat_o = byte_cnt;
            default: cfg_dat_o = 32'd0;
        endcase
    end

endmodule
